// File: rtl/traffic_pkg.sv
// Shared types and default timing for the intersection controller.
package traffic_pkg;

  localparam int unsigned STATE_W          = 3;
  localparam int unsigned CNT_W_DEF        = 8;
  localparam int unsigned MIN_GREEN_T_DEF  = 6;
  localparam int unsigned SIDE_GREEN_T_DEF = 8;
  localparam int unsigned YELLOW_T_DEF     = 1;
  localparam int unsigned ALLRED_T_DEF     = 1;
  localparam int unsigned PED_CLR_T_DEF    = 2;

  // Fixed state codes; state_o exposes them directly.
  typedef enum logic [STATE_W-1:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALLRED_1    = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALLRED_2    = 3'd5,
    FLASH       = 3'd6
  } tl_state_t;

  // One road's lamp head.
  typedef struct packed {
    logic g;
    logic y;
    logic r;
  } lamp_t;

  localparam lamp_t LAMP_G   = 3'b100;
  localparam lamp_t LAMP_Y   = 3'b010;
  localparam lamp_t LAMP_R   = 3'b001;
  localparam lamp_t LAMP_OFF = 3'b000;

  // Steady-state lamp decode for one road given its own green/yellow states.
  function automatic lamp_t road_lamp(input tl_state_t st,
                                      input tl_state_t green_st,
                                      input tl_state_t yellow_st);
    lamp_t l;
    if (st == green_st)       l = LAMP_G;
    else if (st == yellow_st) l = LAMP_Y;
    else                      l = LAMP_R;
    return l;
  endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_phase_timer.sv
// Per-phase tick counter: cleared on phase change, saturating, with expiry compare.
module phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] dur,
  output logic [CNT_W-1:0] tcnt,
  output logic             expired
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count ticks within the current phase; clear has priority, hold at max.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (clr) begin
      tcnt <= '0;
    end else if (tick && (tcnt != CNT_MAX)) begin
      tcnt <= tcnt + CNT_W'(1);
    end
  end

  // Phase has used its last tick once the count reaches dur-1 (dur is never 0).
  assign expired = (tcnt >= (dur - CNT_W'(1)));

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Actuated main/side intersection controller with pedestrian walk and night flash.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN_T  = MIN_GREEN_T_DEF,
  parameter int unsigned SIDE_GREEN_T = SIDE_GREEN_T_DEF,
  parameter int unsigned YELLOW_T     = YELLOW_T_DEF,
  parameter int unsigned ALLRED_T     = ALLRED_T_DEF,
  parameter int unsigned PED_CLR_T    = PED_CLR_T_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               side_req,
  input  logic               ped_req,
  input  logic               night_mode,
  output logic               main_g,
  output logic               main_y,
  output logic               main_r,
  output logic               side_g,
  output logic               side_y,
  output logic               side_r,
  output logic               walk,
  output logic               ped_pending,
  output logic [STATE_W-1:0] state_o
);

  localparam int unsigned DUR_MAX = (32'd1 << CNT_W) - 32'd1;

  // Reject parameter sets the timer cannot represent.
  if (CNT_W == 0 || CNT_W > 31) begin : g_bad_cnt_w
    $error("CNT_W must be in 1..31");
  end
  if (MIN_GREEN_T == 0 || MIN_GREEN_T > DUR_MAX) begin : g_bad_min_green
    $error("MIN_GREEN_T out of range");
  end
  if (SIDE_GREEN_T == 0 || SIDE_GREEN_T > DUR_MAX) begin : g_bad_side_green
    $error("SIDE_GREEN_T out of range");
  end
  if (YELLOW_T == 0 || YELLOW_T > DUR_MAX) begin : g_bad_yellow
    $error("YELLOW_T out of range");
  end
  if (ALLRED_T == 0 || ALLRED_T > DUR_MAX) begin : g_bad_allred
    $error("ALLRED_T out of range");
  end
  if (PED_CLR_T == 0 || PED_CLR_T > DUR_MAX) begin : g_bad_ped_clr
    $error("PED_CLR_T out of range");
  end
  if (PED_CLR_T >= SIDE_GREEN_T) begin : g_bad_ped_vs_side
    $error("PED_CLR_T must be less than SIDE_GREEN_T");
  end

  localparam logic [CNT_W-1:0] MIN_GREEN_D  = CNT_W'(MIN_GREEN_T);
  localparam logic [CNT_W-1:0] SIDE_GREEN_D = CNT_W'(SIDE_GREEN_T);
  localparam logic [CNT_W-1:0] YELLOW_D     = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] ALLRED_D     = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] WALK_END     = CNT_W'(SIDE_GREEN_T - PED_CLR_T);

  tl_state_t        state;
  tl_state_t        state_nxt;
  logic             state_chg;
  logic             enter_side_green;
  logic [CNT_W-1:0] dur;
  logic [CNT_W-1:0] tcnt;
  logic             expired;
  logic             flash_ph;
  logic             walk_en;
  lamp_t            main_l;
  lamp_t            side_l;

  // Duration of the phase currently being timed.
  always_comb begin
    dur = '1;
    case (state)
      MAIN_GREEN:              dur = MIN_GREEN_D;
      MAIN_YELLOW,
      SIDE_YELLOW:             dur = YELLOW_D;
      ALLRED_1,
      ALLRED_2:                dur = ALLRED_D;
      SIDE_GREEN:              dur = SIDE_GREEN_D;
      default:                 dur = '1;
    endcase
  end

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_chg),
    .tick    (tick),
    .dur     (dur),
    .tcnt    (tcnt),
    .expired (expired)
  );

  // Next-state decision; the phase only moves in a tick cycle.
  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        MAIN_GREEN:  if (expired && (side_req || ped_pending || night_mode)) state_nxt = MAIN_YELLOW;
        MAIN_YELLOW: if (expired) state_nxt = ALLRED_1;
        ALLRED_1:    if (expired) state_nxt = night_mode ? FLASH : SIDE_GREEN;
        SIDE_GREEN:  if (expired) state_nxt = SIDE_YELLOW;
        SIDE_YELLOW: if (expired) state_nxt = ALLRED_2;
        ALLRED_2:    if (expired) state_nxt = night_mode ? FLASH : MAIN_GREEN;
        FLASH:       if (!night_mode) state_nxt = ALLRED_2;
        default:     state_nxt = ALLRED_2;
      endcase
    end
  end

  assign state_chg        = (state_nxt != state);
  assign enter_side_green = state_chg && (state_nxt == SIDE_GREEN);

  // State register, flash phase and pedestrian latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ALLRED_2;
      flash_ph    <= 1'b0;
      ped_pending <= 1'b0;
      walk_en     <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_chg && (state_nxt == FLASH)) begin
        flash_ph <= 1'b1;
      end else if ((state == FLASH) && tick) begin
        flash_ph <= ~flash_ph;
      end

      // A press in the entry cycle is served by this green, so clear wins.
      if (enter_side_green) begin
        ped_pending <= 1'b0;
        walk_en     <= ped_pending | ped_req;
      end else if (ped_req) begin
        ped_pending <= 1'b1;
      end
    end
  end

  // Lamp decode straight from registered state; flash overrides both heads.
  always_comb begin
    main_l = road_lamp(state, MAIN_GREEN, MAIN_YELLOW);
    side_l = road_lamp(state, SIDE_GREEN, SIDE_YELLOW);
    if (state == FLASH) begin
      main_l   = LAMP_OFF;
      main_l.y = flash_ph;
      side_l   = LAMP_OFF;
      side_l.r = flash_ph;
    end
  end

  assign {main_g, main_y, main_r} = main_l;
  assign {side_g, side_y, side_r} = side_l;
  assign walk    = (state == SIDE_GREEN) && walk_en && (tcnt < WALK_END);
  assign state_o = state;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Scoreboard bench for traffic_intersection_ctrl with default parameters.
module tb_traffic_intersection_ctrl;

  localparam logic [2:0] S_MG  = 3'd0;
  localparam logic [2:0] S_MY  = 3'd1;
  localparam logic [2:0] S_AR1 = 3'd2;
  localparam logic [2:0] S_SG  = 3'd3;
  localparam logic [2:0] S_SY  = 3'd4;
  localparam logic [2:0] S_AR2 = 3'd5;
  localparam logic [2:0] S_FL  = 3'd6;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       side_req;
  logic       ped_req;
  logic       night_mode;
  logic       main_g, main_y, main_r;
  logic       side_g, side_y, side_r;
  logic       walk;
  logic       ped_pending;
  logic [2:0] state_o;

  typedef struct packed {
    int unsigned id;
    logic [2:0]  st;
    logic [5:0]  lamps;
    logic        walk;
    logic        pp;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_step  = 0;

  traffic_intersection_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .side_req    (side_req),
    .ped_req     (ped_req),
    .night_mode  (night_mode),
    .main_g      (main_g),
    .main_y      (main_y),
    .main_r      (main_r),
    .side_g      (side_g),
    .side_y      (side_y),
    .side_r      (side_r),
    .walk        (walk),
    .ped_pending (ped_pending),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Lamp vector {main_g,main_y,main_r,side_g,side_y,side_r} expected for a state.
  function automatic logic [5:0] lamps_of(input logic [2:0] st, input logic fph);
    logic [5:0] l;
    case (st)
      S_MG:        l = 6'b100_001;
      S_MY:        l = 6'b010_001;
      S_AR1, S_AR2: l = 6'b001_001;
      S_SG:        l = 6'b001_100;
      S_SY:        l = 6'b001_010;
      S_FL:        l = {1'b0, fph, 1'b0, 1'b0, 1'b0, fph};
      default:     l = 6'b000_000;
    endcase
    return l;
  endfunction

  // One clock of stimulus; the expected post-edge outputs go on the scoreboard.
  task automatic step(input logic t, input logic s, input logic p, input logic n,
                      input logic [2:0] est, input logic efph, input logic ew, input logic epp);
    exp_t x;
    @(negedge clk);
    tick       = t;
    side_req   = s;
    ped_req    = p;
    night_mode = n;
    x.id    = n_step;
    x.st    = est;
    x.lamps = lamps_of(est, efph);
    x.walk  = ew;
    x.pp    = epp;
    sb.push_back(x);
    n_step++;
    @(posedge clk);
    #2;
    tick    = 1'b0;
    ped_req = 1'b0;
  endtask

  // Remainder of a side green after its entry cycle, then back to main green.
  task automatic run_side(input logic w);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0, S_SG, 1'b0, w, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, S_SG, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_SY,  1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_AR2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_MG,  1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state_o), 32'(S_AR2));
    chk({tag, "_lamps"}, 32'({main_g, main_y, main_r, side_g, side_y, side_r}), 32'(6'b001_001));
    chk({tag, "_walk"},  32'(walk), 32'd0);
    chk({tag, "_pend"},  32'(ped_pending), 32'd0);
  endtask

  // Pop and compare one expectation per clock, just after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk($sformatf("state#%0d", e.id), 32'(state_o), 32'(e.st));
      chk($sformatf("lamps#%0d", e.id),
          32'({main_g, main_y, main_r, side_g, side_y, side_r}), 32'(e.lamps));
      chk($sformatf("walk#%0d", e.id), 32'(walk), 32'(e.walk));
      chk($sformatf("pend#%0d", e.id), 32'(ped_pending), 32'(e.pp));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tick = 1'b0; side_req = 1'b0; ped_req = 1'b0; night_mode = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("rst0");
    @(negedge clk);
    reset = 1'b0;

    // Reset recovery: no tick holds all-red, first tick goes to main green.
    step(1'b0, 1'b0, 1'b0, 1'b0, S_AR2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_MG,  1'b0, 1'b0, 1'b0);
    repeat (300) step(1'b1, 1'b0, 1'b0, 1'b0, S_MG, 1'b0, 1'b0, 1'b0);
    chk("tcnt_sat", 32'(dut.u_timer.tcnt), 32'd255);

    // Saturated count still satisfies min green: demand exits at once.
    step(1'b1, 1'b1, 1'b0, 1'b0, S_MY,  1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_AR1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_SG,  1'b0, 1'b0, 1'b0);
    run_side(1'b0);

    // Side request from tick 3; exit on tick 6; a non-tick cycle does not count.
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, S_MG, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, S_MG, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, S_MG, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, S_MY,  1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_AR1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_SG,  1'b0, 1'b0, 1'b0);
    run_side(1'b0);

    // Pedestrian pulse latched in main green, served with walk.
    step(1'b0, 1'b0, 1'b1, 1'b0, S_MG, 1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0, S_MG, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_MY,  1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_AR1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_SG,  1'b0, 1'b1, 1'b0);
    run_side(1'b1);

    // Night mode: through yellow/all-red into flash, press held, then exit.
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1, S_MG, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, S_MY,  1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, S_AR1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, S_FL,  1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, S_FL,  1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, S_FL,  1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, S_FL,  1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, S_FL,  1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_AR2, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_MG,  1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0, S_MG, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_MY,  1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_AR1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_SG,  1'b0, 1'b1, 1'b0);
    run_side(1'b1);

    // Press in the side-green entry cycle: walk on, pending stays clear.
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, S_MG, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, S_MY,  1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_AR1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, S_SG,  1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_SG,  1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, S_SG,  1'b0, 1'b1, 1'b1);

    // Asynchronous reset in the middle of side green.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("rst_hold");
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, S_MG, 1'b0, 1'b0, 1'b0);

    @(posedge clk);
    #3;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
